vga_timing_gen: RTL
===================

# vga_timing_gen

Source end of the pixel-stream interface used throughout the display path: generates `hcount`/`vcount` and the sync and blanking flags that feed the first stage of the drawing chain (background, grid, square and cursor drawing stages). Free-running counters produce XGA 1024x768@60 timing from the 65 MHz pixel clock by default, with all geometry parameterised. Every output is registered and mutually consistent in the same cycle, so downstream stages can treat the bundle as one pipeline word.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, horizontal sync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `H_SYNC_POL`, 1'b0, asserted level of `hsync` (0 = active-low)
- `V_SYNC_POL`, 1'b0, asserted level of `vsync`

Ports:
- `pclk`  in  1  pixel clock, 65 MHz
- `rst`  in  1  synchronous, active-high reset
- `hcount`  out  11  horizontal pixel index, 0..H_TOTAL-1
- `hsync`  out  1  horizontal sync, polarity per `H_SYNC_POL`
- `hblnk`  out  1  horizontal blanking, active-high
- `vcount`  out  11  line index, 0..V_TOTAL-1
- `vsync`  out  1  vertical sync, polarity per `V_SYNC_POL`
- `vblnk`  out  1  vertical blanking, active-high
- `frame_start`  out  1  one-cycle pulse while hcount=0 and vcount=0

## Operation
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806). Both must be ≤ 2048; 11-bit counters, no overflow permitted.
- Horizontal counter: increments by 1 each pclk; at H_TOTAL-1 wraps to 0.
- Vertical counter: increments only on the cycle `hcount` wraps (H_TOTAL-1 -> 0); at V_TOTAL-1 with that wrap, goes to 0. Otherwise holds.
- Flags are pure functions of the registered counts, computed from next-state counts and registered alongside them:
  - `hblnk` = hcount ≥ H_ACTIVE (default 1024..1343).
  - `hsync` asserted for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (default 1048..1183).
  - `vblnk` = vcount ≥ V_ACTIVE (default 768..805), across the whole line including its active pixels.
  - `vsync` asserted for V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (default 771..776).
  - `frame_start` = (hcount==0 && vcount==0).
- Unasserted sync level = inverse of `*_SYNC_POL`.
- No enable, no external sync input; the block never stalls.

## Timing
- Reset (rst high at a pclk edge): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, frame_start=1 (state is pixel 0,0). Reset has priority over counting.
- Reset mid-frame: next edge forces the reset state regardless of current counts; no partial-line completion.
- First edge with rst low after reset: hcount=1, vcount=0, frame_start=0.
- Zero latency between counts and flags: every output reflects the same (hcount,vcount) in the same cycle; no flag lags its count.
- Line period H_TOTAL cycles; frame period H_TOTAL*V_TOTAL = 1,083,264 cycles at defaults; `frame_start` pulses exactly once per frame, one cycle wide.
- Simultaneous wrap: at (1343,805) the next edge yields (0,0), vblnk falls, frame_start rises in the same cycle.

## Test plan
- Reset release: hold rst 5 cycles then release -> during reset outputs (0,0), blanks 0, syncs 1, frame_start 1; first cycle after release hcount=1, frame_start=0.
- Horizontal edges: run one line -> hblnk rises at hcount 1024, hsync low exactly for hcount 1048..1183 (136 cycles), hcount 1343 -> 0 with vcount incrementing 0 -> 1 on that same edge.
- Vertical edges: run to end of frame -> vblnk high for vcount 768..805, vsync low for vcount 771..776 (6 lines = 8064 cycles), wrap (1343,805) -> (0,0).
- Frame period: count cycles between consecutive frame_start pulses -> exactly 1,083,264; each pulse 1 cycle.
- Reset mid-operation: assert rst at (500,400) for 1 cycle -> next state (0,0) with reset flag values; subsequent frame period again 1,083,264.
- Polarity/geometry override: instantiate H_ACTIVE=800,H_FP=40,H_SYNC=128,H_BP=88,V_ACTIVE=600,V_FP=1,V_SYNC=4,V_BP=23, polarities 1 -> hsync high for hcount 840..967, vsync high for vcount 601..604, frame period 1056*628 = 663,168 cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Purpose : free-running raster counters plus sync/blank/frame_start flags (XGA 1024x768@60 by default).
// Latency : every output is registered; all of them describe the same (hcount,vcount) in the same cycle.
// Backpr. : none -- the block never stalls; downstream must accept one pixel word every pclk.
//
// Ports:
//   pclk        pixel clock
//   rst         synchronous active-high reset (forces pixel 0,0)
//   hcount      horizontal pixel index, 0..H_TOTAL-1
//   hsync       horizontal sync, asserted level = H_SYNC_POL
//   hblnk       horizontal blanking (hcount >= H_ACTIVE)
//   vcount      line index, 0..V_TOTAL-1
//   vsync       vertical sync, asserted level = V_SYNC_POL
//   vblnk       vertical blanking (vcount >= V_ACTIVE), held across the whole line
//   frame_start one-cycle pulse while hcount==0 && vcount==0
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 1024,
  parameter int   H_FP       = 24,
  parameter int   H_SYNC     = 136,
  parameter int   H_BP       = 160,
  parameter int   V_ACTIVE   = 768,
  parameter int   V_FP       = 3,
  parameter int   V_SYNC     = 6,
  parameter int   V_BP       = 29,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
);

  // Totals must stay <= 2048 so the 11-bit counters never overflow.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] HBLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] HSYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VBLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] VSYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_nxt;
  logic [10:0] v_nxt;

  // Next-state counts; the vertical counter only moves on the horizontal wrap.
  always_comb begin
    h_nxt = hcount + 11'd1;
    v_nxt = vcount;
    if (hcount == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcount == V_LAST) ? '0 : vcount + 11'd1;
    end
  end

  // Flags are decoded from the next-state counts and registered with them,
  // so no flag lags its count by a cycle.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_nxt >= HBLNK_START);
      vblnk       <= (v_nxt >= VBLNK_START);
      hsync       <= ((h_nxt >= HSYNC_START) && (h_nxt < HSYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= ((v_nxt >= VSYNC_START) && (v_nxt < VSYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule
